// File: rtl/mode_debounce.sv
// Slide-switch conditioner: two-flop synchronizer plus a per-bit restartable
// stability counter, with registered change/rise/fall strobes.
module mode_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] mode_out,
    output logic             changed,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    // Next-state logic: each bit runs its own STABLE/PENDING machine on sync2.
    always_comb begin
        sync1_d  = sw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync2_q[i] != stable_q[i]) begin
                        cnt_d[i]   = CNT_ONE;
                        state_d[i] = ST_PENDING;
                    end else begin
                        cnt_d[i]   = CNT_ZERO;
                    end
                end
                ST_PENDING: begin
                    if (sync2_q[i] == stable_q[i]) begin
                        // Bounced back before the level was trusted: restart.
                        cnt_d[i]   = CNT_ZERO;
                        state_d[i] = ST_STABLE;
                    end else if (cnt_q[i] < CNT_MAX) begin
                        cnt_d[i]   = cnt_q[i] + CNT_ONE;
                    end else begin
                        stable_d[i] = sync2_q[i];
                        rise_d[i]   = sync2_q[i];
                        fall_d[i]   = ~sync2_q[i];
                        cnt_d[i]    = CNT_ZERO;
                        state_d[i]  = ST_STABLE;
                    end
                end
                default: begin
                    cnt_d[i]   = CNT_ZERO;
                    state_d[i] = ST_STABLE;
                end
            endcase
        end
        changed_d = |(rise_d | fall_d);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= CNT_ZERO;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign mode_out = stable_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign changed  = changed_q;

endmodule
